// File: rtl/video_cfg_pkg.sv
// Shared definitions for the video mode configuration block: mode indices,
// FSM state encoding, clock-setting type and a counter-width helper.
// No ports; imported by video_mode_config and sense_debounce.
package video_cfg_pkg;

   // Mode table indices
   localparam int MODE_480I  = 0;
   localparam int MODE_480P  = 1;
   localparam int MODE_VGA   = 2;
   localparam int MODE_SPARE = 3;

   typedef enum logic [1:0] {
      ST_STABLE = 2'd0,
      ST_APPLY  = 2'd1,
      ST_SETTLE = 2'd2
   } state_t;

   // One clock-generator setting at the default setting width
   localparam int CLK_SEL_W_DEF = 4;
   typedef logic [CLK_SEL_W_DEF-1:0] clk_sel_t;

   // Width of a saturating counter able to hold the larger of two limits
   function automatic int cnt_width(input int a, input int b);
      int m;
      m = (a > b) ? a : b;
      return $clog2(m + 1);
   endfunction

endpackage

// File: rtl/video_mode_config_sense_debounce.sv
// Purpose: 2-FF synchroniser plus stability counter for the open-drain 480p sense line.
// Latency: 2 sync cycles, then DEBOUNCE_CYC equal samples before o_sense_n follows.
// Backpressure: none; free-running sampler.
// Ports: i_clock, i_rst_n (async active-low), i_sense_n (raw async line),
//        o_sense_n (accepted, debounced level; 1 after reset = line released).
module sense_debounce
   import video_cfg_pkg::*;
#(
   parameter int DEBOUNCE_CYC = 1024,
   parameter int CNT_W        = cnt_width(DEBOUNCE_CYC, 1)
) (
   input  logic i_clock,
   input  logic i_rst_n,
   input  logic i_sense_n,
   output logic o_sense_n
);

   localparam logic [CNT_W-1:0] DEB_MAX  = CNT_W'(DEBOUNCE_CYC);
   localparam logic [CNT_W-1:0] DEB_LAST = CNT_W'(DEBOUNCE_CYC - 1);

   logic [1:0]       r_sync;    // [0] may be metastable, [1] is safe to use
   logic             r_last;    // value of the current run of equal samples
   logic [CNT_W-1:0] r_cnt;     // length of that run, saturating at DEBOUNCE_CYC
   logic             r_acc;

   always_ff @(posedge i_clock or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_sync <= 2'b11;
         r_last <= 1'b1;
         r_cnt  <= DEB_MAX;
         r_acc  <= 1'b1;
      end else begin
         r_sync <= {r_sync[0], i_sense_n};
         if (r_sync[1] != r_last) begin
            // Toggle: this sample starts a new run
            r_last <= r_sync[1];
            r_cnt  <= CNT_W'(1);
         end else begin
            if (r_cnt != DEB_MAX) begin
               r_cnt <= r_cnt + 1'b1;
            end
            // This sample is the DEBOUNCE_CYC-th (or later) equal one
            if (r_cnt >= DEB_LAST) begin
               r_acc <= r_last;
            end
         end
      end
   end

   assign o_sense_n = r_acc;

endmodule

// File: rtl/video_mode_config.sv
// Purpose: debounce the 480p sense, arbitrate against forced modes, sequence mode changes
//          (config_changed pulse, PLL reset/settle window) and drive per-mode clock/doubler settings.
// Latency: 1 cycle from accepted request change to config_changed; outputs registered.
// Backpressure: none; a new request during settle restarts the window.
// Ports: clock, reset_n (async assert, synchronised release), sense_480p_n, drive_480p_n,
//        force_vga, [force_spare when VIDEO_MODE_SPARE_EN is defined], clk_table,
//        clock_config_S, line_doubler, mode_idx, config_changed, pll_reset_n, stable.
module video_mode_config
   import video_cfg_pkg::*;
#(
   parameter int                   NUM_MODES    = 4,
   parameter int                   CLK_SEL_W    = 4,
   parameter logic [NUM_MODES-1:0] LD_MASK      = {{(NUM_MODES-1){1'b0}}, 1'b1},
   parameter int                   DEBOUNCE_CYC = 1024,
   parameter int                   SETTLE_CYC   = 4096
) (
   input  logic                            clock,
   input  logic                            reset_n,
   input  logic                            sense_480p_n,
   output logic                            drive_480p_n,
   input  logic                            force_vga,
`ifdef VIDEO_MODE_SPARE_EN
   input  logic                            force_spare,
`endif
   input  logic [NUM_MODES*CLK_SEL_W-1:0]  clk_table,
   output logic [CLK_SEL_W-1:0]            clock_config_S,
   output logic                            line_doubler,
   output logic [$clog2(NUM_MODES)-1:0]    mode_idx,
   output logic                            config_changed,
   output logic                            pll_reset_n,
   output logic                            stable
);

   localparam int MODE_W = $clog2(NUM_MODES);
   localparam int CNT_W  = cnt_width(DEBOUNCE_CYC, SETTLE_CYC);

   localparam logic [MODE_W-1:0] M_480I  = MODE_W'(MODE_480I);
   localparam logic [MODE_W-1:0] M_480P  = MODE_W'(MODE_480P);
   localparam logic [MODE_W-1:0] M_VGA   = MODE_W'(MODE_VGA);
`ifdef VIDEO_MODE_SPARE_EN
   // Only meaningful with NUM_MODES >= 4
   localparam logic [MODE_W-1:0] M_SPARE = MODE_W'(MODE_SPARE);
`endif
   localparam logic [CNT_W-1:0]  SETTLE_LAST = CNT_W'(SETTLE_CYC - 1);

   // Reset: asserts immediately, releases two clocks after reset_n rises
   logic [1:0] r_rst_sync;
   logic       w_rst_n;

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         r_rst_sync <= 2'b00;
      end else begin
         r_rst_sync <= {r_rst_sync[0], 1'b1};
      end
   end

   assign w_rst_n = r_rst_sync[1];

   logic w_sense_acc_n;

   sense_debounce #(
      .DEBOUNCE_CYC (DEBOUNCE_CYC),
      .CNT_W        (CNT_W)
   ) u_sense_debounce (
      .i_clock   (clock),
      .i_rst_n   (w_rst_n),
      .i_sense_n (sense_480p_n),
      .o_sense_n (w_sense_acc_n)
   );

   state_t            r_state;
   logic [MODE_W-1:0] r_mode_idx;
   logic              r_cfg_chg;
   logic              r_pll_rst_n;
   logic              r_stable;
   logic              r_drive_480p_n;
   logic [CNT_W-1:0]  r_settle_cnt;

   logic              w_sense_low;
   logic [MODE_W-1:0] w_req;
   logic              w_apply;

   // While we pull the line low ourselves the sense reading is meaningless,
   // so it is treated as an accepted low.
   always_comb begin
      w_sense_low = ~r_drive_480p_n | ~w_sense_acc_n;
      w_req       = M_480I;
      if (force_vga) begin
         w_req = M_VGA;
      end
`ifdef VIDEO_MODE_SPARE_EN
      else if (force_spare) begin
         w_req = M_SPARE;
      end
`endif
      else if (w_sense_low) begin
         w_req = M_480P;
      end
   end

   // APPLY always lasts one cycle; a request change seen there is caught in SETTLE
   assign w_apply = (r_state != ST_APPLY) && (w_req != r_mode_idx);

   always_ff @(posedge clock or negedge w_rst_n) begin
      if (!w_rst_n) begin
         r_state        <= ST_STABLE;
         r_mode_idx     <= M_480I;
         r_cfg_chg      <= 1'b0;
         r_pll_rst_n    <= 1'b0;
         r_stable       <= 1'b0;
         r_drive_480p_n <= 1'b1;
         r_settle_cnt   <= '0;
      end else begin
         r_cfg_chg <= 1'b0;
         if (w_apply) begin
            r_state        <= ST_APPLY;
            r_mode_idx     <= w_req;
            r_cfg_chg      <= 1'b1;
            r_pll_rst_n    <= 1'b0;
            r_stable       <= 1'b0;
            r_drive_480p_n <= (w_req != M_VGA);
         end else begin
            case (r_state)
               ST_STABLE: begin
                  // PLL reset still low here only straight after reset: run one settle window
                  if (!r_pll_rst_n) begin
                     r_state      <= ST_SETTLE;
                     r_settle_cnt <= '0;
                  end
               end
               ST_APPLY: begin
                  r_state      <= ST_SETTLE;
                  r_settle_cnt <= '0;
               end
               ST_SETTLE: begin
                  if (r_settle_cnt == SETTLE_LAST) begin
                     r_state     <= ST_STABLE;
                     r_pll_rst_n <= 1'b1;
                     r_stable    <= 1'b1;
                  end else begin
                     r_settle_cnt <= r_settle_cnt + 1'b1;
                  end
               end
               default: begin
                  r_state <= ST_STABLE;
               end
            endcase
         end
      end
   end

   // Table lookup from the registered mode index
   logic [CLK_SEL_W-1:0] w_clk_sel;
   logic                 w_ld;

   always_comb begin
      w_clk_sel = clk_table[CLK_SEL_W-1:0];
      w_ld      = LD_MASK[0];
      for (int i = 1; i < NUM_MODES; i++) begin
         if (r_mode_idx == MODE_W'(i)) begin
            w_clk_sel = clk_table[i*CLK_SEL_W +: CLK_SEL_W];
            w_ld      = LD_MASK[i];
         end
      end
   end

   assign clock_config_S = w_clk_sel;
   assign line_doubler   = w_ld;
   assign mode_idx       = r_mode_idx;
   assign config_changed = r_cfg_chg;
   assign pll_reset_n    = r_pll_rst_n;
   assign stable         = r_stable;
   assign drive_480p_n   = r_drive_480p_n;

endmodule

// File: tb/tb_video_mode_config.sv
// Directed bench for video_mode_config at default parameters
// (NUM_MODES=4, CLK_SEL_W=4, LD_MASK=0001, DEBOUNCE_CYC=1024, SETTLE_CYC=4096).
module tb_video_mode_config;
   import video_cfg_pkg::*;

   localparam clk_sel_t T0 = 4'hA;
   localparam clk_sel_t T1 = 4'hB;
   localparam clk_sel_t T2 = 4'hC;
   localparam clk_sel_t T3 = 4'hD;

   logic        clock = 1'b0;
   logic        reset_n;
   logic        sense_480p_n;
   logic        drive_480p_n;
   logic        force_vga;
`ifdef VIDEO_MODE_SPARE_EN
   logic        force_spare;
`endif
   logic [15:0] clk_table;
   logic [3:0]  clock_config_S;
   logic        line_doubler;
   logic [1:0]  mode_idx;
   logic        config_changed;
   logic        pll_reset_n;
   logic        stable;

   int vectors = 0;
   int errors  = 0;
   int n;
   int pulses;

   video_mode_config dut (
      .clock          (clock),
      .reset_n        (reset_n),
      .sense_480p_n   (sense_480p_n),
      .drive_480p_n   (drive_480p_n),
      .force_vga      (force_vga),
`ifdef VIDEO_MODE_SPARE_EN
      .force_spare    (force_spare),
`endif
      .clk_table      (clk_table),
      .clock_config_S (clock_config_S),
      .line_doubler   (line_doubler),
      .mode_idx       (mode_idx),
      .config_changed (config_changed),
      .pll_reset_n    (pll_reset_n),
      .stable         (stable)
   );

   always #5 clock = ~clock;

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic wait_stable(input int limit, output int cnt);
      cnt = 0;
      while (stable !== 1'b1 && cnt < limit) begin
         tick();
         cnt++;
      end
   endtask

   task automatic wait_cfg(input int limit, output int cnt);
      cnt = 0;
      while (config_changed !== 1'b1 && cnt < limit) begin
         tick();
         cnt++;
      end
   endtask

   task automatic chk_reset_vals(input string tag);
      chk({tag, "_mode"},   32'(mode_idx), 32'd0);
      chk({tag, "_pll"},    32'(pll_reset_n), 32'd0);
      chk({tag, "_stable"}, 32'(stable), 32'd0);
      chk({tag, "_cfg"},    32'(config_changed), 32'd0);
      chk({tag, "_drive"},  32'(drive_480p_n), 32'd1);
      chk({tag, "_clk"},    32'(clock_config_S), 32'(T0));
      chk({tag, "_ld"},     32'(line_doubler), 32'd1);
   endtask

   initial begin
      clk_table    = {T3, T2, T1, T0};
      reset_n      = 1'b0;
      sense_480p_n = 1'b1;
      force_vga    = 1'b0;
`ifdef VIDEO_MODE_SPARE_EN
      force_spare  = 1'b0;
`endif
      tick(); tick(); tick();
      chk_reset_vals("rst");

      // Reset release: 2 sync cycles + 1 STABLE cycle + 4096 SETTLE cycles
      reset_n = 1'b1;
      wait_stable(6000, n);
      chk("init_settle_len", 32'(n), 32'd4099);
      chk("init_pll",  32'(pll_reset_n), 32'd1);
      chk("init_mode", 32'(mode_idx), 32'd0);
      chk("init_clk",  32'(clock_config_S), 32'(T0));
      chk("init_ld",   32'(line_doubler), 32'd1);

      // Glitch low for 500 cycles: never accepted
      sense_480p_n = 1'b0;
      pulses = 0;
      for (int i = 0; i < 500; i++) begin
         tick();
         if (config_changed === 1'b1) pulses++;
      end
      sense_480p_n = 1'b1;
      for (int i = 0; i < 1100; i++) begin
         tick();
         if (config_changed === 1'b1) pulses++;
      end
      chk("glitch_pulses", 32'(pulses), 32'd0);
      chk("glitch_mode",   32'(mode_idx), 32'd0);
      chk("glitch_stable", 32'(stable), 32'd1);

      // Sense low held: pulse after 1024+3 edges
      sense_480p_n = 1'b0;
      wait_cfg(1200, n);
      chk("p480_latency", 32'(n), 32'd1027);
      chk("p480_mode",    32'(mode_idx), 32'd1);
      chk("p480_ld",      32'(line_doubler), 32'd0);
      chk("p480_clk",     32'(clock_config_S), 32'(T1));
      chk("p480_drive",   32'(drive_480p_n), 32'd1);
      chk("p480_pll",     32'(pll_reset_n), 32'd0);
      tick();
      chk("p480_pulse_end", 32'(config_changed), 32'd0);

      // Back to 480i mid-settle (~settle cycle 1990): second pulse, window restarts
      for (int i = 0; i < 960; i++) tick();
      sense_480p_n = 1'b1;
      wait_cfg(1200, n);
      chk("restart_latency", 32'(n), 32'd1027);
      chk("restart_mode",    32'(mode_idx), 32'd0);
      chk("restart_stable",  32'(stable), 32'd0);
      chk("restart_clk",     32'(clock_config_S), 32'(T0));
      wait_stable(6000, n);
      chk("restart_settle_len", 32'(n), 32'd4097);
      chk("restart_pll",        32'(pll_reset_n), 32'd1);

      // Forced VGA bypasses debounce
      force_vga = 1'b1;
      tick();
      chk("vga_cfg",   32'(config_changed), 32'd1);
      chk("vga_mode",  32'(mode_idx), 32'd2);
      chk("vga_drive", 32'(drive_480p_n), 32'd0);
      chk("vga_clk",   32'(clock_config_S), 32'(T2));
      chk("vga_ld",    32'(line_doubler), 32'd0);
      wait_stable(6000, n);
      chk("vga_settle_len", 32'(n), 32'd4097);
      chk("vga_drive_hold", 32'(drive_480p_n), 32'd0);

      // Release: own drive counts as low -> 480p, then released line -> 480i
      force_vga = 1'b0;
      tick();
      chk("unvga_cfg1",  32'(config_changed), 32'd1);
      chk("unvga_mode1", 32'(mode_idx), 32'd1);
      chk("unvga_drive", 32'(drive_480p_n), 32'd1);
      tick();
      chk("unvga_gap", 32'(config_changed), 32'd0);
      tick();
      chk("unvga_cfg2",  32'(config_changed), 32'd1);
      chk("unvga_mode2", 32'(mode_idx), 32'd0);
      wait_stable(6000, n);
      chk("unvga_settle_len", 32'(n), 32'd4097);

      // Reset during settle acts immediately
      force_vga = 1'b1;
      tick();
      chk("pre_rst_mode", 32'(mode_idx), 32'd2);
      for (int i = 0; i < 100; i++) tick();
      reset_n = 1'b0;
      #1;
      chk_reset_vals("midrst");
      force_vga = 1'b0;
      tick(); tick();
      reset_n = 1'b1;
      wait_stable(6000, n);
      chk("rerelease_settle_len", 32'(n), 32'd4099);
      chk("rerelease_mode",       32'(mode_idx), 32'd0);

`ifdef VIDEO_MODE_SPARE_EN
      force_spare = 1'b1;
      tick();
      chk("spare_cfg",  32'(config_changed), 32'd1);
      chk("spare_mode", 32'(mode_idx), 32'd3);
      chk("spare_clk",  32'(clock_config_S), 32'(T3));
      force_vga = 1'b1;
      tick(); tick();
      chk("vga_over_spare", 32'(mode_idx), 32'd2);
`endif

      $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
      $finish;
   end

endmodule
